// File: rtl/seq_detect_pkg.sv
// Shared defaults and helpers for the seq_detect_n serial pattern detector.
package seq_detect_pkg;

  localparam int DEF_PAT_W = 2;
  localparam logic [1:0] DEF_PATTERN = 2'b01;
  localparam int DEF_CNT_W = 8;

  // All-ones value of a cnt_w-bit counter, computed wide so cnt_w up to 63 is safe.
  function automatic logic [63:0] cnt_sat_value(input int cnt_w);
    return (64'd1 << cnt_w) - 64'd1;
  endfunction

endpackage

// File: rtl/seq_window.sv
// Sliding window over the last PAT_W-1 accepted bits plus a saturating fill
// count; o_match is the combinational compare for the current edge.
module seq_window #(
  parameter int             PAT_W   = 2,
  parameter logic [PAT_W-1:0] PATTERN = 2'b01,
  parameter bit             OVERLAP = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_x,
  input  logic i_clr,
  output logic o_match
);

  generate
    if (PAT_W == 1) begin : g_single
      assign o_match = i_en & ~i_clr & (i_x == PATTERN[0]);
    end else begin : g_window
      localparam int HW = PAT_W - 1;
      localparam int FW = $clog2(PAT_W);
      localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);

      logic [HW-1:0]    r_hist;
      logic [FW-1:0]    r_fill;
      logic [PAT_W-1:0] w_shift;
      logic             w_full;
      logic             w_match;

      assign w_shift = {r_hist, i_x};
      assign w_full  = (r_fill == FILL_MAX);
      assign w_match = i_en & ~i_clr & w_full & (w_shift == PATTERN);
      assign o_match = w_match;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_hist <= '0;
          r_fill <= '0;
        end else if (i_clr) begin
          r_hist <= '0;
          r_fill <= '0;
        end else if (i_en) begin
          r_hist <= w_shift[HW-1:0];
          // Non-overlapping mode starts a fresh search so no bit is reused.
          if (w_match && !OVERLAP) begin
            r_fill <= '0;
          end else if (!w_full) begin
            r_fill <= r_fill + 1'b1;
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/seq_detect_n.sv
// Serial pattern detector with registered match pulse z and an optional
// saturating match counter, compiled in when SEQ_DETECT_N_COUNT_EN is defined.
module seq_detect_n
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             clr,
  output logic             z,
  output logic [CNT_W-1:0] cnt,
  output logic             cnt_sat
);

  logic w_match;
  logic r_z;

  seq_window #(
    .PAT_W  (PAT_W),
    .PATTERN(PATTERN),
    .OVERLAP(OVERLAP)
  ) u_window (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_en   (en),
    .i_x    (x),
    .i_clr  (clr),
    .o_match(w_match)
  );

  // w_match is already gated by en and clr, so z needs no extra qualification.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_z <= 1'b0;
    end else begin
      r_z <= w_match;
    end
  end

  assign z = r_z;

`ifdef SEQ_DETECT_N_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat_value(CNT_W));

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (w_match && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt     = r_cnt;
  assign cnt_sat = (r_cnt == CNT_MAX);
`else
  assign cnt     = '0;
  assign cnt_sat = 1'b0;
`endif

endmodule
